// File: rtl/pb_debouncer.sv
// Push-button conditioner: synchroniser, consecutive-sample debounce FSM, clean level and press strobe.
// Optional PB_RELEASE_PULSE_EN macro adds a one-cycle release strobe output.
module pb_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic pbRaw,
    output logic pbLevel,
    output logic pbPulse
`ifdef PB_RELEASE_PULSE_EN
    ,
    output logic pbReleasePulse
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } state_t;

    logic [SYNC_STAGES-1:0] syncQ;
    logic [SYNC_STAGES-1:0] syncD;
    logic                   s;

    state_t                 stateQ;
    logic [CNT_W-1:0]       cntQ;
    logic                   levelQ;
    logic                   pulseQ;
`ifdef PB_RELEASE_PULSE_EN
    logic                   releaseQ;
`endif

    assign syncD = {syncQ[SYNC_STAGES-2:0], pbRaw};
    assign s     = syncQ[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            syncQ <= '0;
        end else begin
            syncQ <= syncD;
        end
    end

    // Strobes default low every cycle, so each accepted edge yields exactly one pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ   <= IDLE_LOW;
            cntQ     <= '0;
            levelQ   <= 1'b0;
            pulseQ   <= 1'b0;
`ifdef PB_RELEASE_PULSE_EN
            releaseQ <= 1'b0;
`endif
        end else begin
            pulseQ   <= 1'b0;
`ifdef PB_RELEASE_PULSE_EN
            releaseQ <= 1'b0;
`endif
            case (stateQ)
                IDLE_LOW: begin
                    if (s) begin
                        stateQ <= WAIT_HIGH;
                        cntQ   <= CNT_W'(1);
                    end else begin
                        cntQ   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        stateQ <= IDLE_LOW;
                        cntQ   <= '0;
                    end else if (cntQ == CNT_LAST) begin
                        stateQ <= STABLE_HIGH;
                        cntQ   <= '0;
                        levelQ <= 1'b1;
                        pulseQ <= 1'b1;
                    end else begin
                        cntQ   <= cntQ + 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!s) begin
                        stateQ <= WAIT_LOW;
                        cntQ   <= CNT_W'(1);
                    end
                end
                WAIT_LOW: begin
                    if (s) begin
                        stateQ <= STABLE_HIGH;
                        cntQ   <= '0;
                    end else if (cntQ == CNT_LAST) begin
                        stateQ   <= IDLE_LOW;
                        cntQ     <= '0;
                        levelQ   <= 1'b0;
`ifdef PB_RELEASE_PULSE_EN
                        releaseQ <= 1'b1;
`endif
                    end else begin
                        cntQ   <= cntQ + 1'b1;
                    end
                end
                default: begin
                    stateQ <= IDLE_LOW;
                    cntQ   <= '0;
                    levelQ <= 1'b0;
                end
            endcase
        end
    end

    assign pbLevel = levelQ;
    assign pbPulse = pulseQ;
`ifdef PB_RELEASE_PULSE_EN
    assign pbReleasePulse = releaseQ;
`endif

endmodule

// File: tb/tb_pb_debouncer.sv
// Directed bench for pb_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4 (press latency 6 edges).
// Release-strobe checks are compiled in when PB_RELEASE_PULSE_EN is defined.
module tb_pb_debouncer;

    logic clk;
    logic reset;
    logic pbRaw;
    logic pbLevel;
    logic pbPulse;
`ifdef PB_RELEASE_PULSE_EN
    logic pbReleasePulse;
`endif

    int checkCount;
    int passCount;

    pb_debouncer #(
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pbRaw(pbRaw),
        .pbLevel(pbLevel),
        .pbPulse(pbPulse)
`ifdef PB_RELEASE_PULSE_EN
        ,
        .pbReleasePulse(pbReleasePulse)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rawVal, input logic rstVal);
        pbRaw = rawVal;
        reset = rstVal;
    endtask

    // Advance one rising edge and settle just past it before sampling.
    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %b, expected %b at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkRelease(input string tag, input logic expected);
`ifdef PB_RELEASE_PULSE_EN
        checkOutput(tag, pbReleasePulse, expected);
`endif
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;

        applyStimulus(1'b0, 1'b1);
        stepEdge();
        checkOutput("rst_level", pbLevel, 1'b0);
        checkOutput("rst_pulse", pbPulse, 1'b0);
        checkRelease("rst_release", 1'b0);
        stepEdge();
        applyStimulus(1'b0, 1'b0);
        for (int e = 1; e <= 3; e++) stepEdge();

        // Clean press held for 20 edges: one pulse at edge 6, level stays high.
        applyStimulus(1'b1, 1'b0);
        for (int e = 1; e <= 20; e++) begin
            stepEdge();
            checkOutput($sformatf("press_pulse_e%0d", e), pbPulse, e == 6);
            checkOutput($sformatf("press_level_e%0d", e), pbLevel, e >= 6);
        end

        // Release: level falls at edge 6 with an optional release strobe there.
        applyStimulus(1'b0, 1'b0);
        for (int e = 1; e <= 12; e++) begin
            stepEdge();
            checkOutput($sformatf("rel_level_e%0d", e), pbLevel, e < 6);
            checkOutput($sformatf("rel_pulse_e%0d", e), pbPulse, 1'b0);
            checkRelease($sformatf("rel_strobe_e%0d", e), e == 6);
        end

        // Glitch: three high samples are one short of acceptance.
        for (int e = 1; e <= 12; e++) begin
            applyStimulus(e <= 3, 1'b0);
            stepEdge();
            checkOutput($sformatf("glitch_pulse_e%0d", e), pbPulse, 1'b0);
            checkOutput($sformatf("glitch_level_e%0d", e), pbLevel, 1'b0);
        end

        // Bounce 1,0,1,0,1 then hold: final rise sampled at edge 5, accepted at edge 10.
        for (int e = 1; e <= 16; e++) begin
            applyStimulus((e >= 5) || (e % 2 == 1), 1'b0);
            stepEdge();
            checkOutput($sformatf("bounce_pulse_e%0d", e), pbPulse, e == 10);
            checkOutput($sformatf("bounce_level_e%0d", e), pbLevel, e >= 10);
        end

        applyStimulus(1'b0, 1'b0);
        for (int e = 1; e <= 8; e++) stepEdge();
        checkOutput("idle_level", pbLevel, 1'b0);

        // Reset mid-press in WAIT_HIGH, then a fresh full-latency press after deassertion.
        applyStimulus(1'b1, 1'b0);
        for (int e = 1; e <= 3; e++) stepEdge();
        applyStimulus(1'b1, 1'b1);
        stepEdge();
        checkOutput("midrst_pulse", pbPulse, 1'b0);
        checkOutput("midrst_level", pbLevel, 1'b0);
        applyStimulus(1'b1, 1'b0);
        for (int e = 1; e <= 10; e++) begin
            stepEdge();
            checkOutput($sformatf("postrst_pulse_e%0d", e), pbPulse, e == 6);
            checkOutput($sformatf("postrst_level_e%0d", e), pbLevel, e >= 6);
        end

        applyStimulus(1'b0, 1'b0);
        for (int e = 1; e <= 8; e++) stepEdge();
        checkOutput("idle2_level", pbLevel, 1'b0);

        // Reset coinciding with the accepting edge must suppress the pulse.
        applyStimulus(1'b1, 1'b0);
        for (int e = 1; e <= 5; e++) stepEdge();
        applyStimulus(1'b1, 1'b1);
        stepEdge();
        checkOutput("rstwin_pulse", pbPulse, 1'b0);
        checkOutput("rstwin_level", pbLevel, 1'b0);
        applyStimulus(1'b1, 1'b0);
        stepEdge();
        checkOutput("rstwin_after_pulse", pbPulse, 1'b0);
        checkOutput("rstwin_after_level", pbLevel, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
